// File: rtl/spirometer_control.sv
// Spirometer measurement sequencer: waits for a blow, gates the flow accumulator,
// detects end of exhalation (silence or sample limit) and latches the final volume.
module spirometer_control #(
   parameter logic [7:0]  UMBRAL_INICIO = 8'd10,
   parameter logic [7:0]  UMBRAL_FIN    = 8'd5,
   parameter logic [3:0]  N_SILENCIO    = 4'd8,
   parameter logic [9:0]  MAX_MUESTRAS  = 10'd600,
   parameter logic [11:0] MAX_ESPERA    = 12'd2000
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iStart,
   input  logic        iAbort,
   input  logic        iDatoValido,
   input  logic [7:0]  ivDatos,
   input  logic [13:0] ivVolumen,
   output logic        oCE,
   output logic [1:0]  ovStateMachine,
   output logic [9:0]  ovMuestras,
   output logic [13:0] ovVolumenFinal,
   output logic        oListo,
   output logic        oTimeout,
   output logic        oError
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ESPERA = 2'b01,
      ST_MEDIR  = 2'b10,
      ST_FIN    = 2'b11
   } state_t;

   state_t      state_q;
   logic [9:0]  muestras_q, muestras_d;
   logic [3:0]  sil_q, sil_d;
   logic [11:0] espera_q, espera_d;
   logic [13:0] vol_q;
   logic        listo_q, timeout_q, error_q;
   logic        cap_pend_q;

   // Candidate counter values for the sample being presented this cycle
   always_comb begin
      muestras_d = muestras_q;
      sil_d      = sil_q;
      espera_d   = espera_q + 12'd1;
      if (muestras_q >= MAX_MUESTRAS) begin
         muestras_d = MAX_MUESTRAS;
      end else begin
         muestras_d = muestras_q + 10'd1;
      end
      if (ivDatos < UMBRAL_FIN) begin
         sil_d = sil_q + 4'd1;
      end else begin
         sil_d = 4'd0;
      end
   end

   // Measurement FSM with all status outputs registered alongside the state
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         state_q    <= ST_IDLE;
         muestras_q <= 10'd0;
         sil_q      <= 4'd0;
         espera_q   <= 12'd0;
         vol_q      <= 14'd0;
         listo_q    <= 1'b0;
         timeout_q  <= 1'b0;
         error_q    <= 1'b0;
         cap_pend_q <= 1'b0;
      end else if (iAbort) begin
         state_q    <= ST_IDLE;
         listo_q    <= 1'b0;
         cap_pend_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (iStart) begin
                  state_q    <= ST_ESPERA;
                  muestras_q <= 10'd0;
                  sil_q      <= 4'd0;
                  espera_q   <= 12'd0;
                  timeout_q  <= 1'b0;
                  error_q    <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ESPERA: begin
               if (!iDatoValido) begin
                  state_q <= ST_ESPERA;
               end else if (ivDatos >= UMBRAL_INICIO) begin
                  state_q <= ST_MEDIR;
               end else if (espera_d == MAX_ESPERA) begin
                  espera_q <= espera_d;
                  error_q  <= 1'b1;
                  state_q  <= ST_IDLE;
               end else begin
                  espera_q <= espera_d;
               end
            end
            ST_MEDIR: begin
               if (iDatoValido) begin
                  muestras_q <= muestras_d;
                  sil_q      <= sil_d;
                  // Silence is tested first so it wins a tie with the sample limit
                  if (sil_d == N_SILENCIO) begin
                     state_q    <= ST_FIN;
                     timeout_q  <= 1'b0;
                     listo_q    <= 1'b1;
                     cap_pend_q <= 1'b1;
                  end else if (muestras_d == MAX_MUESTRAS) begin
                     state_q    <= ST_FIN;
                     timeout_q  <= 1'b1;
                     listo_q    <= 1'b1;
                     cap_pend_q <= 1'b1;
                  end else begin
                     state_q <= ST_MEDIR;
                  end
               end else begin
                  state_q <= ST_MEDIR;
               end
            end
            ST_FIN: begin
               // Accumulator output lags one cycle, so capture after the first FIN cycle
               cap_pend_q <= 1'b0;
               if (cap_pend_q) begin
                  vol_q <= ivVolumen;
               end else begin
                  vol_q <= vol_q;
               end
               if (iStart) begin
                  state_q <= ST_IDLE;
                  listo_q <= 1'b0;
               end else begin
                  state_q <= ST_FIN;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               listo_q    <= 1'b0;
               cap_pend_q <= 1'b0;
            end
         endcase
      end
   end

   assign oCE            = iDatoValido & (state_q == ST_MEDIR);
   assign ovStateMachine = state_q;
   assign ovMuestras     = muestras_q;
   assign ovVolumenFinal = vol_q;
   assign oListo         = listo_q;
   assign oTimeout       = timeout_q;
   assign oError         = error_q;

endmodule

// File: tb/tb_spirometer_control.sv
// Self-checking bench for spirometer_control with an external flow-accumulator model
// and a result scoreboard checked once per completed measurement.
module tb_spirometer_control;

   logic        iClk = 1'b0;
   logic        iReset = 1'b0;
   logic        iStart = 1'b0;
   logic        iAbort = 1'b0;
   logic        iDatoValido = 1'b0;
   logic [7:0]  ivDatos = 8'd0;
   logic [13:0] ivVolumen;
   logic        oCE;
   logic [1:0]  ovStateMachine;
   logic [9:0]  ovMuestras;
   logic [13:0] ovVolumenFinal;
   logic        oListo, oTimeout, oError;

   typedef struct {
      logic [13:0] vol;
      logic [9:0]  muestras;
      logic        timeout;
   } result_t;

   result_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int ce_cnt = 0;
   logic listo_prev = 1'b0;
   logic res_seen = 1'b0;
   logic [13:0] acc_q;
   logic [13:0] exp_vol;

   spirometer_control dut (
      .iClk(iClk), .iReset(iReset), .iStart(iStart), .iAbort(iAbort),
      .iDatoValido(iDatoValido), .ivDatos(ivDatos), .ivVolumen(ivVolumen),
      .oCE(oCE), .ovStateMachine(ovStateMachine), .ovMuestras(ovMuestras),
      .ovVolumenFinal(ovVolumenFinal), .oListo(oListo), .oTimeout(oTimeout),
      .oError(oError)
   );

   always #5 iClk = ~iClk;

   // External flow accumulator: cleared in IDLE, adds the sample on each oCE
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) acc_q <= 14'd0;
      else if (ovStateMachine == 2'b00) acc_q <= 14'd0;
      else if (oCE) acc_q <= acc_q + {6'd0, ivDatos};
   end
   assign ivVolumen = acc_q;

   always @(posedge iClk) if (oCE) ce_cnt = ce_cnt + 1;

   // Scoreboard: compare the latched result in the second FIN cycle
   always @(negedge iClk) begin
      result_t e;
      if (oListo && listo_prev && !res_seen) begin
         res_seen = 1'b1;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: result appeared with nothing expected");
         end else begin
            e = exp_q.pop_front();
            if (ovVolumenFinal !== e.vol) begin
               failures++;
               $display("FAIL sb_vol: got %0d expected %0d", ovVolumenFinal, e.vol);
            end
            checks++;
            if (ovMuestras !== e.muestras) begin
               failures++;
               $display("FAIL sb_muestras: got %0d expected %0d", ovMuestras, e.muestras);
            end
            checks++;
            if (oTimeout !== e.timeout) begin
               failures++;
               $display("FAIL sb_timeout: got %0b expected %0b", oTimeout, e.timeout);
            end
         end
      end
      if (!oListo) res_seen = 1'b0;
      listo_prev = oListo;
   end

   task automatic pulse_start();
      @(negedge iClk) iStart = 1'b1;
      @(negedge iClk) iStart = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge iClk) begin ivDatos = d; iDatoValido = 1'b1; end
      @(negedge iClk) iDatoValido = 1'b0;
   endtask

   task automatic wait_sb(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge iClk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_no_result: got %0d pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      iReset = 1'b0;
      iDatoValido = 1'b1;
      repeat (2) @(negedge iClk);
      checks++; if (ovStateMachine !== 2'b00) begin failures++; $display("FAIL rst_state: got %b expected 00", ovStateMachine); end
      checks++; if (oCE !== 1'b0) begin failures++; $display("FAIL rst_ce: got %b expected 0", oCE); end
      checks++; if (ovMuestras !== 10'd0) begin failures++; $display("FAIL rst_muestras: got %0d expected 0", ovMuestras); end
      checks++; if (ovVolumenFinal !== 14'd0) begin failures++; $display("FAIL rst_vol: got %0d expected 0", ovVolumenFinal); end
      checks++; if ({oListo, oTimeout, oError} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b expected 000", {oListo, oTimeout, oError}); end
      iDatoValido = 1'b0;
      iReset = 1'b1;
      send(8'd50);
      checks++; if (ce_cnt !== 0 || ovStateMachine !== 2'b00) begin failures++; $display("FAIL idle_ignore: got ce=%0d st=%b expected ce=0 st=00", ce_cnt, ovStateMachine); end
   endtask

   task automatic test_normal();
      ce_cnt = 0;
      pulse_start();
      send(8'd20);
      checks++; if (ovStateMachine !== 2'b10 || ce_cnt !== 0) begin failures++; $display("FAIL norm_trigger: got st=%b ce=%0d expected st=10 ce=0", ovStateMachine, ce_cnt); end
      pulse_start();
      checks++; if (ovStateMachine !== 2'b10) begin failures++; $display("FAIL norm_start_ignored: got %b expected 10", ovStateMachine); end
      exp_vol = 14'd0;
      for (int i = 0; i < 5; i++) exp_vol = exp_vol + 14'd30;
      for (int i = 0; i < 8; i++) exp_vol = exp_vol + 14'd2;
      exp_q.push_back('{vol: exp_vol, muestras: 10'd13, timeout: 1'b0});
      repeat (5) send(8'd30);
      repeat (7) send(8'd2);
      checks++; if (ovStateMachine !== 2'b10) begin failures++; $display("FAIL norm_before_end: got %b expected 10", ovStateMachine); end
      send(8'd2);
      checks++; if (ovStateMachine !== 2'b11 || oListo !== 1'b1) begin failures++; $display("FAIL norm_fin: got st=%b listo=%b expected st=11 listo=1", ovStateMachine, oListo); end
      wait_sb("norm");
      checks++; if (ce_cnt !== 13) begin failures++; $display("FAIL norm_ce_count: got %0d expected 13", ce_cnt); end
      send(8'd90);
      pulse_start();
      checks++; if (ovStateMachine !== 2'b00 || oListo !== 1'b0 || ovVolumenFinal !== 14'd166) begin failures++; $display("FAIL norm_ack: got st=%b listo=%b vol=%0d expected st=00 listo=0 vol=166", ovStateMachine, oListo, ovVolumenFinal); end
   endtask

   task automatic test_silence_restart();
      ce_cnt = 0;
      pulse_start();
      send(8'd50);
      exp_q.push_back('{vol: 14'd40, muestras: 10'd16, timeout: 1'b0});
      repeat (7) send(8'd2);
      send(8'd10);
      repeat (7) send(8'd2);
      checks++; if (ovStateMachine !== 2'b10) begin failures++; $display("FAIL sil_restart: got %b expected 10", ovStateMachine); end
      send(8'd2);
      wait_sb("sil");
      checks++; if (ce_cnt !== 16) begin failures++; $display("FAIL sil_ce_count: got %0d expected 16", ce_cnt); end
      pulse_start();
   endtask

   task automatic test_wait_timeout();
      ce_cnt = 0;
      pulse_start();
      repeat (1999) send(8'd3);
      checks++; if (ovStateMachine !== 2'b01 || oError !== 1'b0) begin failures++; $display("FAIL wait_1999: got st=%b err=%b expected st=01 err=0", ovStateMachine, oError); end
      send(8'd3);
      checks++; if (ovStateMachine !== 2'b00 || oError !== 1'b1 || ce_cnt !== 0) begin failures++; $display("FAIL wait_expire: got st=%b err=%b ce=%0d expected st=00 err=1 ce=0", ovStateMachine, oError, ce_cnt); end
      repeat (3) @(negedge iClk);
      checks++; if (oError !== 1'b1) begin failures++; $display("FAIL wait_err_hold: got %b expected 1", oError); end
   endtask

   task automatic test_max_samples();
      ce_cnt = 0;
      pulse_start();
      checks++; if (oError !== 1'b0 || ovStateMachine !== 2'b01) begin failures++; $display("FAIL max_start_clear: got err=%b st=%b expected err=0 st=01", oError, ovStateMachine); end
      send(8'd50);
      exp_vol = 14'd0;
      for (int i = 0; i < 600; i++) exp_vol = exp_vol + 14'd50;
      exp_q.push_back('{vol: exp_vol, muestras: 10'd600, timeout: 1'b1});
      repeat (600) send(8'd50);
      wait_sb("max");
      checks++; if (ce_cnt !== 600 || ovStateMachine !== 2'b11) begin failures++; $display("FAIL max_end: got ce=%0d st=%b expected ce=600 st=11", ce_cnt, ovStateMachine); end
      pulse_start();
      checks++; if (oTimeout !== 1'b1 || ovVolumenFinal !== exp_vol) begin failures++; $display("FAIL max_hold: got to=%b vol=%0d expected to=1 vol=%0d", oTimeout, ovVolumenFinal, exp_vol); end
   endtask

   task automatic test_tie();
      pulse_start();
      send(8'd60);
      exp_vol = 14'd0;
      for (int i = 0; i < 592; i++) exp_vol = exp_vol + 14'd50;
      for (int i = 0; i < 8; i++) exp_vol = exp_vol + 14'd2;
      exp_q.push_back('{vol: exp_vol, muestras: 10'd600, timeout: 1'b0});
      repeat (592) send(8'd50);
      repeat (8) send(8'd2);
      wait_sb("tie");
      pulse_start();
   endtask

   task automatic test_abort();
      logic [13:0] held;
      held = ovVolumenFinal;
      pulse_start();
      send(8'd40);
      repeat (3) send(8'd40);
      @(negedge iClk) begin iAbort = 1'b1; iDatoValido = 1'b1; ivDatos = 8'd2; end
      @(negedge iClk) begin iAbort = 1'b0; iDatoValido = 1'b0; end
      checks++; if (ovStateMachine !== 2'b00 || oListo !== 1'b0) begin failures++; $display("FAIL abort_state: got st=%b listo=%b expected st=00 listo=0", ovStateMachine, oListo); end
      checks++; if (ovVolumenFinal !== held) begin failures++; $display("FAIL abort_vol: got %0d expected %0d", ovVolumenFinal, held); end
   endtask

   task automatic test_reset_mid();
      ce_cnt = 0;
      pulse_start();
      send(8'd30);
      repeat (4) send(8'd30);
      @(negedge iClk);
      #2 begin iReset = 1'b0; iDatoValido = 1'b1; ivDatos = 8'd30; end
      #1;
      checks++; if (ovStateMachine !== 2'b00 || ovMuestras !== 10'd0 || oCE !== 1'b0) begin failures++; $display("FAIL rstmid_async: got st=%b m=%0d ce=%b expected st=00 m=0 ce=0", ovStateMachine, ovMuestras, oCE); end
      checks++; if (ovVolumenFinal !== 14'd0 || {oListo, oTimeout, oError} !== 3'b000) begin failures++; $display("FAIL rstmid_outputs: got vol=%0d flags=%b expected vol=0 flags=000", ovVolumenFinal, {oListo, oTimeout, oError}); end
      @(negedge iClk) begin iReset = 1'b1; iDatoValido = 1'b0; end
      ce_cnt = 0;
      pulse_start();
      send(8'd20);
      exp_q.push_back('{vol: 14'd68, muestras: 10'd10, timeout: 1'b0});
      repeat (2) send(8'd30);
      repeat (8) send(8'd1);
      wait_sb("rstmid");
      checks++; if (ce_cnt !== 10) begin failures++; $display("FAIL rstmid_ce_count: got %0d expected 10", ce_cnt); end
      pulse_start();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_silence_restart();
      test_wait_timeout();
      test_max_samples();
      test_tie();
      test_abort();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spirometer_control.md
SPIROMETER_CONTROL -- requirements
Module: spirometer_control

Interface
REQ-001 SHALL have parameter UMBRAL_INICIO, default 8'd10, the flow threshold that starts a measurement.
REQ-002 SHALL have parameter UMBRAL_FIN, default 8'd5, the flow threshold below which a sample counts as silence.
REQ-003 SHALL have parameter N_SILENCIO, default 4'd8, the number of consecutive silent samples that ends a measurement.
REQ-004 SHALL have parameter MAX_MUESTRAS, default 10'd600, the accumulated-sample limit that forces the end of a measurement.
REQ-005 SHALL have parameter MAX_ESPERA, default 12'd2000, the valid-sample limit while waiting for a blow.
REQ-006 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-007 iReset  in  1  asynchronous, active-low reset.
REQ-008 iStart  in  1  single-cycle request to start a measurement, or to acknowledge a result.
REQ-009 iAbort  in  1  return to IDLE from any state.
REQ-010 iDatoValido  in  1  one-cycle strobe marking a new flow sample.
REQ-011 ivDatos  in  8  unsigned flow sample, qualified by iDatoValido.
REQ-012 ivVolumen  in  14  running volume from the flow accumulator.
REQ-013 oCE  out  1  accumulate-enable to the flow accumulator.
REQ-014 ovStateMachine  out  2  state code to the accumulator: 00 IDLE (clear), 01 ESPERA, 10 MEDIR, 11 FIN.
REQ-015 ovMuestras  out  10  number of samples accumulated in the current measurement.
REQ-016 ovVolumenFinal  out  14  latched final volume.
REQ-017 oListo  out  1  high while a result is held.
REQ-018 oTimeout  out  1  the measurement ended by hitting MAX_MUESTRAS.
REQ-019 oError  out  1  ESPERA expired without a blow.

Function
REQ-020 SHALL implement a registered FSM with states IDLE, ESPERA, MEDIR and FIN; ovStateMachine SHALL equal the current state code.
REQ-021 IDLE: on iStart, go to ESPERA and clear ovMuestras, the silence counter, the wait counter, oTimeout and oError.
REQ-022 ESPERA: each valid sample with ivDatos >= UMBRAL_INICIO moves to MEDIR; that triggering sample is not accumulated.
REQ-023 ESPERA: each valid sample below UMBRAL_INICIO increments the wait counter; reaching MAX_ESPERA goes to IDLE with oError=1, and oError stays set until the next iStart.
REQ-024 oCE SHALL be combinational, equal to iDatoValido AND (state==MEDIR), so the accumulator sees the strobe in the same cycle.
REQ-025 MEDIR: each oCE pulse increments ovMuestras, which saturates at MAX_MUESTRAS.
REQ-026 MEDIR: a valid sample with ivDatos < UMBRAL_FIN increments the silence counter; a valid sample >= UMBRAL_FIN clears it.
REQ-027 MEDIR: when the silence counter reaches N_SILENCIO, go to FIN with oTimeout=0.
REQ-028 MEDIR: when ovMuestras reaches MAX_MUESTRAS, go to FIN with oTimeout=1.
REQ-029 MEDIR: if the silence and sample-limit conditions occur on the same sample, silence SHALL win and oTimeout=0.
REQ-030 FIN: ovVolumenFinal SHALL capture ivVolumen at the clock edge ending the first FIN cycle (one-cycle latency for the last accumulation); oListo=1 for the whole of FIN.
REQ-031 FIN: iStart moves to IDLE; ovVolumenFinal and oTimeout SHALL be held until the next IDLE->ESPERA transition.
REQ-032 iAbort SHALL take priority over every other transition: go to IDLE next cycle, without updating ovVolumenFinal.
REQ-033 iStart outside IDLE and FIN, and iDatoValido in IDLE or FIN, SHALL be ignored.

Reset
REQ-034 While iReset=0: state IDLE, ovStateMachine=00, oCE=0, ovMuestras=0, ovVolumenFinal=0, oListo=0, oTimeout=0, oError=0, all internal counters 0.
REQ-035 Reset asserted mid-measurement SHALL abandon it immediately with no result latched; operation resumes on the first clock edge after release.

Verification
REQ-036 iStart; valid sample 20; 5 samples of 30; 8 samples of 2 -> MEDIR after the 20; 13 oCE pulses; FIN after the 8th silent sample; oTimeout=0; ovMuestras=13; ovVolumenFinal=ivVolumen.
REQ-037 iStart; 2000 valid samples of 3 -> IDLE, oError=1, no oCE pulses.
REQ-038 iStart; trigger 50; 600 samples of 50 -> FIN with oTimeout=1, ovMuestras=600.
REQ-039 Silence run of 7 then a sample of 10 then 8 silent samples -> the counter restarts and FIN follows the 16th sample after the trigger.
REQ-040 iAbort in MEDIR together with iDatoValido -> IDLE next cycle, ovStateMachine=00, ovVolumenFinal unchanged.
REQ-041 iReset low during MEDIR -> all outputs at reset values asynchronously; after release, iStart starts a clean measurement.
